mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 66 ++++++
 rtl/mem_access_load_ext.sv | 35 +++
 rtl/mem_access.sv | 155 +++++++++++++++
 tb/tb_mem_access.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and decode helpers for the mem_access stage: memory op codes,
// exception codes, FSM states, byte-enable and store-lane replication.
package mem_access_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  localparam logic [2:0] EXC_NONE   = 3'd0;
  localparam logic [2:0] EXC_OVF    = 3'd1;
  localparam logic [2:0] EXC_ADEL   = 3'd2;
  localparam logic [2:0] EXC_ADES   = 3'd3;
  localparam logic [2:0] EXC_BUSERR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
    logic word_op;
    logic half_op;
    word_op = (op == OP_LW) || (op == OP_SW);
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    return (word_op && (lane != 2'b00)) || (half_op && lane[0]);
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      OP_SH:   be = lane[1] ? 4'b1100 : 4'b0011;
      OP_SB:   be = 4'b0001 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    case (op)
      OP_SH:   d = {wdata[15:0], wdata[15:0]};
      OP_SB:   d = {4{wdata[7:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// load_ext: picks the addressed byte/halfword lane of a read word and
// sign- or zero-extends it according to the load op.
module load_ext
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (lane)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (op)
      OP_LB:   data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data = {24'd0, byte_v};
      OP_LH:   data = {{16{half_v[15]}}, half_v};
      OP_LHU:  data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: takes an execute result, issues at most one data-memory
// access, and produces a writeback or exception pulse. MEM_TIMEOUT_EN adds a bus timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_ovf,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        exc_valid,
  output logic [2:0]  exc_code,
  output logic [1:0]  state
);

  // Handshake: a result transfers on a rising edge where ex_valid && ex_ready;
  // ex_ready depends only on internal state, never on ex_valid.
  state_e      state_q, state_d;
  logic        run_q;
  logic        accept, mem_ld, mem_st, bad_align, go_mem, timeout, done;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] ld_data;

  assign ex_ready  = run_q && (state_q == ST_IDLE);
  assign accept    = ex_valid && ex_ready;
  assign mem_ld    = is_load(ex_mem_op);
  assign mem_st    = is_store(ex_mem_op);
  assign bad_align = misaligned(ex_mem_op, ex_addr[1:0]);
  assign go_mem    = accept && !ex_ovf && !bad_align && (mem_ld || mem_st);
  assign done      = (state_q == ST_REQ) && (dm_ack || timeout);
  assign state     = state_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q != ST_REQ) begin
      cnt_q <= '0;
    end else if (!timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == ST_REQ) && !dm_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  // No limit in this build: the comparison is constant false, REQ waits for dm_ack.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  load_ext u_load_ext (
    .op    (op_q),
    .lane  (lane_q),
    .rdata (dm_rdata),
    .data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go_mem) state_d = ST_REQ;
      ST_REQ:  if (done)   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_be     <= '0;
      dm_wdata  <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
      op_q      <= '0;
      lane_q    <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
      if (accept) begin
        wb_rd <= ex_rd;
        if (ex_ovf || bad_align) begin
          wb_valid  <= 1'b1;
          wb_we     <= 1'b0;
          wb_data   <= '0;
          exc_valid <= 1'b1;
          exc_code  <= ex_ovf ? EXC_OVF : (mem_ld ? EXC_ADEL : EXC_ADES);
        end else if (go_mem) begin
          op_q     <= ex_mem_op;
          lane_q   <= ex_addr[1:0];
          dm_req   <= 1'b1;
          dm_we    <= mem_st;
          dm_addr  <= {ex_addr[31:2], 2'b00};
          dm_be    <= byte_en(ex_mem_op, ex_addr[1:0]);
          dm_wdata <= store_data(ex_mem_op, ex_wdata);
        end else begin
          wb_valid <= 1'b1;
          wb_we    <= (ex_rd != 5'd0);
          wb_data  <= ex_addr;
        end
      end else if (done) begin
        dm_req   <= 1'b0;
        dm_we    <= 1'b0;
        wb_valid <= 1'b1;
        if (dm_ack) begin
          wb_we   <= is_load(op_q) && (wb_rd != 5'd0);
          wb_data <= is_load(op_q) ? ld_data : 32'd0;
        end else begin
          wb_we     <= 1'b0;
          wb_data   <= '0;
          exc_valid <= 1'b1;
          exc_code  <= EXC_BUSERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads/stores with lane handling,
// exceptions, stray acks, reset abort, and (with MEM_TIMEOUT_EN) bus timeout.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        ex_ovf;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid, wb_we;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        exc_valid;
  logic [2:0]  exc_code;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                         LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_rd(ex_rd), .ex_ovf(ex_ovf),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data), .wb_rd(wb_rd),
    .exc_valid(exc_valid), .exc_code(exc_code), .state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one result and lets it be accepted at the next posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic ovf);
    ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_ovf = ovf;
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic mem_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int delay,
                         input logic [31:0] rdata, input logic [31:0] exp_daddr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_dwe,
                         input logic [31:0] exp_wb, input logic exp_wbwe);
    check({tag, ".ready"}, ex_ready, 1);
    issue(op, addr, wdata, rd, 1'b0);
    for (int i = 0; i <= delay; i++) begin
      check({tag, ".req"}, dm_req, 1);
      check({tag, ".addr"}, dm_addr, exp_daddr);
      check({tag, ".be"}, dm_be, exp_be);
      check({tag, ".wdata"}, dm_wdata, exp_wd);
      check({tag, ".we"}, dm_we, exp_dwe);
      check({tag, ".wbidle"}, wb_valid, 0);
      if (i == delay) begin dm_ack = 1'b1; dm_rdata = rdata; end
      @(negedge clk);
    end
    dm_ack = 1'b0; dm_rdata = 32'h0;
    check({tag, ".wbv"}, wb_valid, 1);
    check({tag, ".wbd"}, wb_data, exp_wb);
    check({tag, ".wbwe"}, wb_we, exp_wbwe);
    check({tag, ".wbrd"}, wb_rd, rd);
    check({tag, ".exc"}, exc_valid, 0);
    check({tag, ".reqoff"}, dm_req, 0);
    check({tag, ".busy"}, ex_ready, 0);
    @(negedge clk);
    check({tag, ".pulse"}, wb_valid, 0);
    check({tag, ".ready2"}, ex_ready, 1);
  endtask

  task automatic exc_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic ovf, input logic [2:0] exp_code);
    issue(op, addr, 32'h0, 5'd3, ovf);
    check({tag, ".noreq"}, dm_req, 0);
    check({tag, ".wbv"}, wb_valid, 1);
    check({tag, ".wbwe"}, wb_we, 0);
    check({tag, ".excv"}, exc_valid, 1);
    check({tag, ".code"}, exc_code, exp_code);
    check({tag, ".ready"}, ex_ready, 1);
    @(negedge clk);
    check({tag, ".pulse"}, exc_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_mem_op = '0;
    ex_rd = '0; ex_ovf = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    #3;
    check("rst.ready", ex_ready, 0);
    check("rst.req", dm_req, 0);
    check("rst.wbv", wb_valid, 0);
    check("rst.state", fsm_state, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("rel.ready0", ex_ready, 0);
    @(negedge clk);
    check("rel.ready1", ex_ready, 1);

    // Pass-through
    issue(NONE, 32'h1234, 32'h0, 5'd5, 1'b0);
    check("none.wbv", wb_valid, 1);
    check("none.wbd", wb_data, 32'h1234);
    check("none.wbwe", wb_we, 1);
    check("none.rd", wb_rd, 5);
    check("none.state", fsm_state, 0);
    @(negedge clk);
    check("none.pulse", wb_valid, 0);
    issue(NONE, 32'hCAFE_0001, 32'h0, 5'd0, 1'b0);
    check("none0.wbwe", wb_we, 0);
    check("none0.wbd", wb_data, 32'hCAFE_0001);
    @(negedge clk);

    // Loads and stores
    mem_txn("lb",  LB,  32'h103, 32'h0, 5'd7, 3, 32'h80FF_FF7F, 32'h100, 4'b1111, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1);
    mem_txn("lbu", LBU, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_FF7F, 32'h100, 4'b1111, 32'h0, 1'b0, 32'h0000_0080, 1'b1);
    mem_txn("lb0", LB,  32'h100, 32'h0, 5'd8, 0, 32'h80FF_FF7F, 32'h100, 4'b1111, 32'h0, 1'b0, 32'h0000_007F, 1'b1);
    mem_txn("lh",  LH,  32'h102, 32'h0, 5'd9, 0, 32'h80FF_FF7F, 32'h100, 4'b1111, 32'h0, 1'b0, 32'hFFFF_80FF, 1'b1);
    mem_txn("lhu", LHU, 32'h102, 32'h0, 5'd9, 2, 32'h80FF_FF7F, 32'h100, 4'b1111, 32'h0, 1'b0, 32'h0000_80FF, 1'b1);
    mem_txn("lw",  LW,  32'h104, 32'h0, 5'd0, 0, 32'h1357_9BDF, 32'h104, 4'b1111, 32'h0, 1'b0, 32'h1357_9BDF, 1'b0);
    mem_txn("sh",  SH,  32'h202, 32'h0000_ABCD, 5'd4, 1, 32'h0, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0, 1'b0);
    mem_txn("shl", SH,  32'h200, 32'h1111_5678, 5'd4, 0, 32'h0, 32'h200, 4'b0011, 32'h5678_5678, 1'b1, 32'h0, 1'b0);
    mem_txn("sb",  SB,  32'h201, 32'h1234_5678, 5'd2, 0, 32'h0, 32'h200, 4'b0010, 32'h7878_7878, 1'b1, 32'h0, 1'b0);
    mem_txn("sw",  SW,  32'h30C, 32'hDEAD_BEEF, 5'd2, 2, 32'h0, 32'h30C, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);

    // Exceptions
    exc_txn("adel", LW, 32'h101, 1'b0, 3'd2);
    exc_txn("ovf",  LW, 32'h101, 1'b1, 3'd1);
    exc_txn("ades", SH, 32'h201, 1'b0, 3'd3);
    exc_txn("ovfn", NONE, 32'h0, 1'b1, 3'd1);

    // Stray ack in IDLE is ignored
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    check("stray.wbv", wb_valid, 0);
    check("stray.state", fsm_state, 0);

    // Reset while a request is outstanding
    issue(LW, 32'h100, 32'h0, 5'd6, 1'b0);
    check("rreq.req", dm_req, 1);
    rst_n = 1'b0;
    #1;
    check("rreq.req0", dm_req, 0);
    check("rreq.addr0", dm_addr, 0);
    check("rreq.be0", dm_be, 0);
    check("rreq.ready0", ex_ready, 0);
    check("rreq.state", fsm_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rreq.ready1", ex_ready, 1);
    check("rreq.wbv", wb_valid, 0);
    check("rreq.exc", exc_valid, 0);

`ifdef MEM_TIMEOUT_EN
    issue(LW, 32'h100, 32'h0, 5'd6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("to.req", dm_req, 1);
      @(negedge clk);
    end
    check("to.reqoff", dm_req, 0);
    check("to.wbv", wb_valid, 1);
    check("to.wbwe", wb_we, 0);
    check("to.excv", exc_valid, 1);
    check("to.code", exc_code, 3'd4);
    @(negedge clk);
    check("to.ready", ex_ready, 1);
    check("to.state", fsm_state, 0);
`else
    issue(LW, 32'h100, 32'h0, 5'd6, 1'b0);
    repeat (20) @(negedge clk);
    check("wait.req", dm_req, 1);
    check("wait.exc", exc_valid, 0);
    dm_ack = 1'b1; dm_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    dm_ack = 1'b0;
    check("wait.wbd", wb_data, 32'h0BAD_F00D);
    @(negedge clk);
    check("wait.ready", ex_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
